bram_stream_reader: RTL and testbench

Sequential read-out engine placed directly downstream of the true dual-port block RAM. It takes a start command with a base address and a word count, drives one RAM port in read-only mode and absorbs the RAM's one-cycle read latency. It also absorbs backpressure through a 2-entry output buffer, presenting the words in address order on a valid/ready stream to the next processing stage. It sustains one word per cycle when the consumer never stalls.

---
 rtl/bram_stream_reader.sv | 126 ++++++++++++
 tb/tb_bram_stream_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams len words from a sync-read RAM starting at base through a 2-entry buffer; BRAM_READER_WRAP_EN enables modulo-MEM_SIZE address wrap
module bram_stream_reader #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 3840
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_i,
  input  logic [AWIDTH:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic              ce_o,
  output logic              we_o,
  input  logic [DWIDTH-1:0] q_i,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  input  logic              m_ready_i
);
  localparam int LW = AWIDTH + 2;
  localparam logic [LW-1:0] MS = LW'(MEM_SIZE);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d, nxt_addr;
  logic [AWIDTH:0] rem_q, rem_d, del_q, del_d;
  logic inflight_q, inflight_d, done_q, done_d, err_q, err_d;
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] count_q, count_d;
  logic [DWIDTH-1:0] mem_q [2];
  logic [DWIDTH-1:0] mem_d [2];
  logic pop, ce, bad;
  // command decode, read issue throttled by buffer occupancy, return capture and delivery count
  always_comb begin
    pop = count_q != 2'd0 && m_ready_i;
    ce = state_q == RUN && (3'(count_q) + 3'(inflight_q) - 3'(pop)) < 3'd2;
`ifdef BRAM_READER_WRAP_EN
    bad = LW'(base_i) >= MS || LW'(len_i) > MS;
    nxt_addr = addr_q == AWIDTH'(MEM_SIZE - 1) ? '0 : addr_q + AWIDTH'(1);
`else
    bad = LW'(base_i) >= MS || LW'(len_i) > MS || LW'(base_i) + LW'(len_i) > MS;
    nxt_addr = addr_q + AWIDTH'(1);
`endif
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    del_d = del_q;
    done_d = 1'b0;
    err_d = 1'b0;
    wr_d = wr_q;
    rd_d = rd_q;
    mem_d = mem_q;
    inflight_d = ce;
    count_d = 2'(3'(count_q) + 3'(inflight_q) - 3'(pop));
    if (state_q == IDLE && start_i) begin
      err_d = bad;
      done_d = !bad && len_i == '0;
      if (!bad && len_i != '0) begin
        state_d = RUN;
        addr_d = base_i;
        rem_d = len_i;
        del_d = len_i;
      end
    end
    if (ce) begin
      addr_d = nxt_addr;
      rem_d = rem_q - (AWIDTH+1)'(1);
      state_d = rem_q == (AWIDTH+1)'(1) ? FLUSH : RUN;
    end
    if (inflight_q) begin
      mem_d[wr_q] = q_i;
      wr_d = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
      del_d = del_q - (AWIDTH+1)'(1);
      if (del_q == (AWIDTH+1)'(1)) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  // state register; reset flushes buffer and drops any pending RAM return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      del_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      del_q <= del_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
      err_q <= err_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  // a return arriving while both entries are held and none leaves would be lost
  always_ff @(posedge clk) begin
    if (!rst) assert (!(inflight_q && !pop && count_q == 2'd2));
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign err_o = err_q;
  assign addr_o = addr_q;
  assign ce_o = ce;
  assign we_o = 1'b0;
  assign m_valid_o = count_q != 2'd0;
  assign m_data_o = mem_q[rd_q];
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed checks of the stream reader against a RAM preloaded with ram[a] = a
module tb_bram_stream_reader;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, m_ready_i = 1'b1;
  logic [11:0] base_i = '0;
  logic [12:0] len_i = '0;
  logic busy_o, done_o, err_o, ce_o, we_o, m_valid_o;
  logic [11:0] addr_o;
  logic [15:0] q_i = '0, m_data_o, prev_data;
  logic prev_stall = 1'b0;
  int total = 0, bad = 0, ce_cnt = 0, done_cnt = 0, err_cnt = 0, stall_bad = 0;
  logic [15:0] got [$];

  bram_stream_reader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .addr_o(addr_o),
    .ce_o(ce_o), .we_o(we_o), .q_i(q_i), .m_valid_o(m_valid_o),
    .m_data_o(m_data_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ce_o) q_i <= 16'(addr_o);

  always @(negedge clk) begin
    if (ce_o) ce_cnt++;
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (m_valid_o && m_ready_i) got.push_back(m_data_o);
    if (prev_stall && m_data_o !== prev_data) stall_bad++;
    prev_stall = m_valid_o && !m_ready_i && !rst;
    prev_data = m_data_o;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear;
    ce_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    stall_bad = 0;
    got.delete();
  endtask

  task automatic go(input int b, input int l);
    base_i = 12'(b);
    len_i = 13'(l);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done_o && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(done_o), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_valid", 32'(m_valid_o), 32'd0);
    check("reset_data", 32'(m_data_o), 32'd0);
    check("reset_ce", 32'(ce_o), 32'd0);
    check("reset_we", 32'(we_o), 32'd0);
    rst = 1'b0;
    tick();

    clear();
    go(10, 4);
    check("t1_ce_c1", 32'(ce_o), 32'd1);
    check("t1_addr_c1", 32'(addr_o), 32'd10);
    check("t1_busy_c1", 32'(busy_o), 32'd1);
    tick();
    check("t1_valid_c2", 32'(m_valid_o), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 32'(m_valid_o), 32'd1);
      check("t1_data", 32'(m_data_o), 32'(10 + i));
      tick();
    end
    check("t1_done_c7", 32'(done_o), 32'd1);
    check("t1_busy_c7", 32'(busy_o), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done_o), 32'd0);
    check("t1_ce_count", 32'(ce_cnt), 32'd4);

    clear();
    go(0, 8);
    for (int c = 1; c < 200 && !done_o; c++) begin
      m_ready_i = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    check("t2_done", 32'(done_o), 32'd1);
    m_ready_i = 1'b1;
    check("t2_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t2_word", 32'(got[i]), 32'(i));
    check("t2_stall_stable", 32'(stall_bad), 32'd0);
    check("t2_ce_count", 32'(ce_cnt), 32'd8);
    tick();

    clear();
    go(3838, 4);
`ifdef BRAM_READER_WRAP_EN
    wait_done("t3_done", 20);
    check("t3_count", 32'(got.size()), 32'd4);
    check("t3_w0", 32'(got[0]), 32'd3838);
    check("t3_w1", 32'(got[1]), 32'd3839);
    check("t3_w2", 32'(got[2]), 32'd0);
    check("t3_w3", 32'(got[3]), 32'd1);
`else
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    tick();
    check("t3_err_pulse", 32'(err_o), 32'd0);
    tick();
    tick();
    check("t3_no_ce", 32'(ce_cnt), 32'd0);
    check("t3_no_done", 32'(done_cnt), 32'd0);
`endif
    tick();

    clear();
    go(5, 0);
    check("t4_zero_done", 32'(done_o), 32'd1);
    check("t4_zero_busy", 32'(busy_o), 32'd0);
    tick();
    check("t4_zero_pulse", 32'(done_o), 32'd0);
    check("t4_zero_ce", 32'(ce_cnt), 32'd0);
    clear();
    go(100, 16);
    tick();
    tick();
    go(0, 3);
    wait_done("t4_done", 60);
    check("t4_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("t4_word", 32'(got[i]), 32'(100 + i));
    check("t4_ce_count", 32'(ce_cnt), 32'd16);
    tick();

    clear();
    go(0, 20);
    for (int i = 0; i < 4; i++) tick();
    check("t5_ce_c5", 32'(ce_o), 32'd1);
    check("t5_addr_c5", 32'(addr_o), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_done", 32'(done_o), 32'd0);
    check("t5_err", 32'(err_o), 32'd0);
    check("t5_ce", 32'(ce_o), 32'd0);
    check("t5_we", 32'(we_o), 32'd0);
    check("t5_addr", 32'(addr_o), 32'd0);
    check("t5_valid", 32'(m_valid_o), 32'd0);
    check("t5_data", 32'(m_data_o), 32'd0);
    rst = 1'b0;
    tick();
    clear();
    go(0, 2);
    wait_done("t5_done2", 20);
    check("t5_count", 32'(got.size()), 32'd2);
    check("t5_w0", 32'(got[0]), 32'd0);
    check("t5_w1", 32'(got[1]), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
